// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared widths, control FSM states and queue entry type for the fetch queue
package instr_fetch_queue_pkg;

    // Default program-counter and instruction widths
    localparam int IFQ_PC_W    = 64;
    localparam int IFQ_INSTR_W = 32;

    // FETCH: normal operation. FLUSH: the cycle after a redirect, where any
    // in-flight response still belongs to the old path and is dropped.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

    // One queue entry: the fetched instruction and the address it came from
    typedef struct packed {
        logic [IFQ_INSTR_W-1:0] instr;
        logic [IFQ_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular entry store for the fetch queue with push, pop, flush and occupancy count
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_flush        empties the queue this cycle (push and pop are ignored)
//   i_push         write i_push_data at the tail (caller never pushes when full)
//   i_push_data    entry to write
//   i_pop          retire the head entry (ignored when empty)
//   o_head_data    entry at the head pointer
//   o_count        number of occupied entries, 0..DEPTH
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 96,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    // DEPTH is a power of two, so pointer wrap is plain binary overflow
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Entry storage needs no reset: count gates everything read from it
    always_ff @(posedge clk) begin
        if (w_do_push && !reset) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - credit-based instruction fetch unit feeding a small in-order instruction queue
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   imem_req, imem_addr      fetch request and byte address to instruction memory
//   imem_rdata               instruction returned one cycle after imem_req
//   redirect, redirect_pc    flush the queue and restart fetch at redirect_pc
//   instr_valid, instr_ready head handshake toward decode
//   instr, instr_pc          head instruction and its address
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = IFQ_PC_W,
    parameter int INSTR_W = IFQ_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_resp_pc;
    logic            r_inflight;
    fetch_state_t    r_state;

    logic [CNT_W-1:0]        w_count;
    logic [INSTR_W+PC_W-1:0] w_head;
    logic                    w_credit_ok;
    logic                    w_req;
    logic                    w_kill;
    logic                    w_push;
    logic                    w_pop;

    // A request is a credit on a queue slot; the outstanding one counts too,
    // so the response always finds room. A same-cycle pop is not credited.
    assign w_credit_ok = (w_count + CNT_W'(r_inflight)) < CNT_W'(DEPTH);
    assign w_req       = !reset && !redirect && w_credit_ok;

    // Responses arriving during the redirect cycle or the FLUSH cycle belong
    // to the abandoned path
    assign w_kill = redirect || (r_state == ST_FLUSH);
    assign w_push = r_inflight && !w_kill;
    assign w_pop  = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
            r_state    <= ST_FETCH;
        end else begin
            r_state    <= redirect ? ST_FLUSH : ST_FETCH;
            r_inflight <= w_req;
            if (w_req) begin
                r_resp_pc <= r_pc;
            end
            // Redirect wins; the latest redirect_pc is always the one kept
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_req) begin
                r_pc <= r_pc + PC_W'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (INSTR_W + PC_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (redirect),
        .i_push      (w_push),
        .i_push_data ({imem_rdata, r_resp_pc}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = !reset && (w_count != '0);
    assign instr       = w_head[INSTR_W+PC_W-1:PC_W];
    assign instr_pc    = w_head[PC_W-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed vector bench for instr_fetch_queue
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_0000;
    endfunction

    // Memory model: data for a request appears one cycle later, junk otherwise
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_of(imem_addr) : 32'hBAD0_BAD0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic        e_req;
        logic        chk_addr;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic redir, input logic [63:0] rpc, input logic rdy,
                       input logic e_req, input logic chk_addr, input logic [63:0] e_addr,
                       input logic e_valid, input logic [63:0] e_pc);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.chk_addr = chk_addr; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic run_stream(input int ncyc, input bit alt, input int min_got);
        logic [63:0] exp_pc = 64'h0;
        int got = 0;
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            reset = 1'b0;
            instr_ready = alt ? (k % 2 == 0) : 1'b1;
            #1;
            if (!alt) chk($sformatf("stream_valid[%0d]", k), 64'(instr_valid), 64'(k >= 2));
            chk($sformatf("count_le_depth[%0d]", k), 64'(dut.u_fifo.o_count <= 4), 64'h1);
            if (instr_valid && instr_ready) begin
                chk($sformatf("stream_pc[%0d]", k), instr_pc, exp_pc);
                chk($sformatf("stream_instr[%0d]", k), 64'(instr), 64'(word_of(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                got++;
            end
        end
        chk(alt ? "alt_delivered" : "steady_delivered", 64'(got >= min_got), 64'h1);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        // Stall from reset release, then drain, redirect, double redirect,
        // PC wrap and reset mid-fetch
        add(1, 0, 0, 0,  0, 1, 64'h0,   0, 0);
        add(1, 0, 0, 0,  0, 1, 64'h0,   0, 0);
        add(0, 0, 0, 0,  1, 1, 64'h0,   0, 0);
        add(0, 0, 0, 0,  1, 1, 64'h4,   0, 0);
        add(0, 0, 0, 0,  1, 1, 64'h8,   1, 64'h0);
        add(0, 0, 0, 0,  1, 1, 64'hC,   1, 64'h0);
        add(0, 0, 0, 0,  0, 1, 64'h10,  1, 64'h0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 1, 64'h10, 1, 64'h0);
        add(0, 0, 0, 1,  0, 1, 64'h10,  1, 64'h0);
        add(0, 0, 0, 1,  1, 1, 64'h10,  1, 64'h4);
        add(0, 0, 0, 1,  1, 1, 64'h14,  1, 64'h8);
        add(0, 0, 0, 1,  1, 1, 64'h18,  1, 64'hC);
        add(0, 0, 0, 1,  1, 1, 64'h1C,  1, 64'h10);
        add(0, 0, 0, 0,  1, 1, 64'h20,  1, 64'h14);
        add(0, 1, 64'h100, 1,  0, 1, 64'h24,  1, 64'h14);
        add(0, 0, 0, 1,  1, 1, 64'h100, 0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h104, 0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h108, 1, 64'h100);
        add(0, 1, 64'h200, 1,  0, 1, 64'h10C, 1, 64'h104);
        add(0, 1, 64'h300, 1,  0, 1, 64'h200, 0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h300, 0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h304, 0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h308, 1, 64'h300);
        add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1,  0, 1, 64'h30C, 1, 64'h304);
        add(0, 0, 0, 1,  1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h0,   0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h4,   1, 64'hFFFF_FFFF_FFFF_FFFC);
        add(0, 0, 0, 1,  1, 1, 64'h8,   1, 64'h0);
        add(1, 0, 0, 1,  0, 0, 64'h0,   0, 0);
        add(1, 0, 0, 1,  0, 1, 64'h0,   0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h0,   0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h4,   0, 0);
        add(0, 0, 0, 1,  1, 1, 64'h8,   1, 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset       = vecs[i].rst;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            instr_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_req", i), 64'(imem_req), 64'(vecs[i].e_req));
            chk($sformatf("v%0d_valid", i), 64'(instr_valid), 64'(vecs[i].e_valid));
            if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_instr", i), 64'(instr), 64'(word_of(vecs[i].e_pc)));
            end
        end

        // Steady stream at one instruction per cycle, then alternating ready
        run_stream(20, 1'b0, 18);
        run_stream(40, 1'b1, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
